// File: rtl/inst_rom_loader.sv
// inst_rom_loader
//   Instruction memory for the CPU fetch port. It also contains a byte-stream
//   program loader that fills the word array. The loader holds the core in
//   reset while a load is running.
//
//   Load stream format: a 4-byte little-endian word count N, followed by N
//   little-endian instruction words. If N exceeds the array depth, the load is
//   rejected and ld_err_o is set.
//
// Ports
//   clk, rst     single clock; synchronous active-high reset
//   rom_ce_i     fetch enable from core
//   rom_addr_i   byte address from core PC (bits [1:0] ignored)
//   rom_data_o   instruction word, combinational read
//   ld_start_i   one-cycle pulse: begin program load (honoured only when idle)
//   ld_valid_i   loader byte valid
//   ld_byte_i    loader byte
//   ld_ready_o   loader accepts a byte this cycle
//   ld_done_o    one-cycle pulse after the last byte of a successful load
//   ld_err_o     sticky: header word count exceeded depth
//   cpu_rst_o    reset to core: rst, or any load in progress
module inst_rom_loader #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  input  logic        ld_start_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_byte_i,
  output logic        ld_ready_o,
  output logic        ld_done_o,
  output logic        ld_err_o,
  output logic        cpu_rst_o
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [32:0] DEPTH_33 = 33'(1) << DEPTH_LOG2;

  typedef enum logic [1:0] {RUN, HDR, DATA} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_bcnt;
  logic [DEPTH_LOG2:0]   r_widx;
  logic [DEPTH_LOG2:0]   r_count;
  logic [23:0]           r_shift;
  logic                  r_done;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_last;
  logic [31:0]           w_assembled;
  logic [DEPTH_LOG2:0]   w_widx_inc;
  logic                  w_hdr_zero;
  logic                  w_hdr_over;
  logic                  w_enter_hdr;
  logic                  w_set_done;
  logic                  w_set_err;
  logic                  w_mem_we;
  logic                  w_addr_hi_nz;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                  w_unused_addr;

  assign ld_ready_o = (r_state == HDR) || (r_state == DATA);
  assign ld_done_o  = r_done;
  assign ld_err_o   = r_err;
  assign cpu_rst_o  = rst || (r_state != RUN);

  assign w_accept = ld_valid_i && ld_ready_o;
  assign w_last   = w_accept && (r_bcnt == 2'd3);

  // The three earlier bytes sit in r_shift with the first byte lowest. The
  // current byte completes the word without waiting for another clock.
  assign w_assembled = {ld_byte_i, r_shift};
  assign w_widx_inc  = r_widx + 1'b1;
  assign w_hdr_zero  = (w_assembled == 32'd0);
  assign w_hdr_over  = ({1'b0, w_assembled} > DEPTH_33);

  always_comb begin
    w_state_nxt = r_state;
    w_enter_hdr = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      RUN: begin
        if (ld_start_i) begin
          w_state_nxt = HDR;
          w_enter_hdr = 1'b1;
        end
      end
      HDR: begin
        if (w_last) begin
          if (w_hdr_zero) begin
            w_state_nxt = RUN;
            w_set_done  = 1'b1;
          end else if (w_hdr_over) begin
            w_state_nxt = RUN;
            w_set_err   = 1'b1;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_last) begin
          w_mem_we = 1'b1;
          if (w_widx_inc == r_count) begin
            w_state_nxt = RUN;
            w_set_done  = 1'b1;
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_widx  <= '0;
      r_count <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_set_done;
      if (w_enter_hdr) begin
        r_bcnt  <= '0;
        r_widx  <= '0;
        r_shift <= '0;
        r_err   <= 1'b0;
      end else if (w_accept) begin
        r_shift <= {ld_byte_i, r_shift[23:8]};
        r_bcnt  <= r_bcnt + 1'b1;
        // An accepted count is at most DEPTH, so it fits in DEPTH_LOG2+1 bits.
        if ((r_state == HDR) && w_last) begin
          r_count <= w_assembled[DEPTH_LOG2:0];
        end
        if (w_mem_we) begin
          r_widx <= w_widx_inc;
        end
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // The array is not reset. Its contents survive rst and aborted loads.
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      r_mem[r_widx[DEPTH_LOG2-1:0]] <= w_assembled;
    end
  end

  assign w_addr_hi_nz  = |rom_addr_i[31:DEPTH_LOG2+2];
  assign w_rd_idx      = rom_addr_i[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^rom_addr_i[1:0];

  always_comb begin
    rom_data_o = '0;
    if (rom_ce_i && !rst && (r_state == RUN)) begin
      rom_data_o = w_addr_hi_nz ? NOP_WORD : r_mem[w_rd_idx];
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

  localparam int          DL2   = 10;
  localparam int          DEPTH = 1 << DL2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ld_start_i;
  logic        ld_valid_i;
  logic [7:0]  ld_byte_i;
  logic        ld_ready_o;
  logic        ld_done_o;
  logic        ld_err_o;
  logic        cpu_rst_o;

  inst_rom_loader #(.DEPTH_LOG2(DL2), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .ld_start_i (ld_start_i),
    .ld_valid_i (ld_valid_i),
    .ld_byte_i  (ld_byte_i),
    .ld_ready_o (ld_ready_o),
    .ld_done_o  (ld_done_o),
    .ld_err_o   (ld_err_o),
    .cpu_rst_o  (cpu_rst_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the word array, plus a record of which words hold a known value.
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  logic [7:0]  g_bytes[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input logic [31:0] addr);
    int idx;
    rom_ce_i   = 1'b1;
    rom_addr_i = addr;
    #1;
    if ((addr >> (DL2 + 2)) != 0) begin
      check_eq("fetch_oor", rom_data_o, NOP);
    end else begin
      idx = int'((addr >> 2) % DEPTH);
      if (ref_known[idx]) check_eq("fetch", rom_data_o, ref_mem[idx]);
    end
    rom_ce_i = 1'b0;
    #1;
    check_eq("fetch_ce0", rom_data_o, 32'd0);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) g_bytes.push_back(w[8*b +: 8]);
  endtask

  // Drives the stream in g_bytes and checks the handshake against the stream rules.
  // If abort_at >= 0, rst is pulsed instead of sending byte number abort_at.
  task automatic run_load(input int min_gap, input int max_gap, input int abort_at);
    logic [31:0] n_val;
    logic [31:0] w;
    bit          fin;
    bit          ok;
    bit          over;
    int          k;
    int          g;
    n_val = '0;
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
    check_eq("start_ready", 32'(ld_ready_o), 32'd1);
    check_eq("start_cpurst", 32'(cpu_rst_o), 32'd1);
    check_eq("start_errclr", 32'(ld_err_o), 32'd0);
    for (int i = 0; i < g_bytes.size(); i++) begin
      g = $urandom_range(max_gap, min_gap);
      repeat (g) begin
        ld_valid_i = 1'b0;
        ld_byte_i  = 8'($urandom);
        ld_start_i = 1'($urandom);
        tick();
        ld_start_i = 1'b0;
        check_eq("gap_ready", 32'(ld_ready_o), 32'd1);
        check_eq("gap_done", 32'(ld_done_o), 32'd0);
      end
      if (i == abort_at) begin
        rst = 1'b1;
        rom_ce_i = 1'b1;
        rom_addr_i = 32'd0;
        #1;
        check_eq("abort_cpurst", 32'(cpu_rst_o), 32'd1);
        check_eq("abort_rdata", rom_data_o, 32'd0);
        tick();
        rst = 1'b0;
        rom_ce_i = 1'b0;
        #1;
        check_eq("abort_ready", 32'(ld_ready_o), 32'd0);
        check_eq("abort_cpurst2", 32'(cpu_rst_o), 32'd0);
        check_eq("abort_done", 32'(ld_done_o), 32'd0);
        check_eq("abort_err", 32'(ld_err_o), 32'd0);
        return;
      end
      ld_valid_i = 1'b1;
      ld_byte_i  = g_bytes[i];
      tick();
      ld_valid_i = 1'b0;
      fin = 0; ok = 0; over = 0;
      if (i < 4) begin
        n_val[8*i +: 8] = g_bytes[i];
        if (i == 3) begin
          if (n_val == 0) begin fin = 1; ok = 1; end
          else if (longint'(n_val) > longint'(DEPTH)) begin fin = 1; over = 1; end
        end
      end else if ((i - 4) % 4 == 3) begin
        k = (i - 4) / 4;
        w = {g_bytes[i], g_bytes[i-1], g_bytes[i-2], g_bytes[i-3]};
        ref_mem[k]   = w;
        ref_known[k] = 1;
        if (longint'(k + 1) == longint'(n_val)) begin fin = 1; ok = 1; end
      end
      if (fin) begin
        check_eq("end_done", 32'(ld_done_o), 32'(ok));
        check_eq("end_err", 32'(ld_err_o), 32'(over));
        check_eq("end_ready", 32'(ld_ready_o), 32'd0);
        check_eq("end_cpurst", 32'(cpu_rst_o), 32'd0);
        tick();
        check_eq("done_1cyc", 32'(ld_done_o), 32'd0);
        return;
      end
      check_eq("mid_cpurst", 32'(cpu_rst_o), 32'd1);
      check_eq("mid_done", 32'(ld_done_o), 32'd0);
    end
    check_eq("stream_ended_early", 32'd0, 32'd1);
  endtask

  task automatic rand_load(input int n, input int max_gap);
    g_bytes.delete();
    push_word(32'(n));
    for (int i = 0; i < n; i++) push_word($urandom);
    run_load(0, max_gap, -1);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = '0;
    ld_start_i = 1'b0; ld_valid_i = 1'b0; ld_byte_i = '0;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 0;
    tick();
    check_eq("rst_cpurst", 32'(cpu_rst_o), 32'd1);
    check_eq("rst_ready", 32'(ld_ready_o), 32'd0);
    check_eq("rst_done", 32'(ld_done_o), 32'd0);
    check_eq("rst_err", 32'(ld_err_o), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("run_cpurst", 32'(cpu_rst_o), 32'd0);

    // Two-word example program
    g_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                8'h93, 8'h05, 8'h20, 8'h00};
    run_load(0, 0, -1);
    rom_ce_i = 1'b1; rom_addr_i = 32'h0; #1;
    check_eq("ex_w0", rom_data_o, 32'h0010_0513);
    rom_addr_i = 32'h4; #1;
    check_eq("ex_w1", rom_data_o, 32'h0020_0593);
    rom_addr_i = 32'h6; #1;
    check_eq("ex_unaligned", rom_data_o, 32'h0020_0593);
    rom_addr_i = 32'h0000_1000; #1;
    check_eq("ex_oor", rom_data_o, NOP);
    rom_ce_i = 1'b0; #1;
    check_eq("ex_ce0", rom_data_o, 32'd0);

    // Reset keeps the array contents
    rst = 1'b1; rom_ce_i = 1'b1; rom_addr_i = 32'h0; #1;
    check_eq("rst_rdata", rom_data_o, 32'd0);
    check_eq("rst_cpurst2", 32'(cpu_rst_o), 32'd1);
    tick();
    rst = 1'b0; #1;
    check_eq("postrst_w0", rom_data_o, 32'h0010_0513);
    rom_ce_i = 1'b0;

    // Header overflow: N = 1025 is rejected
    g_bytes = '{8'h01, 8'h04, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(0, 1, -1);
    check_eq("ovf_err_sticky", 32'(ld_err_o), 32'd1);
    fetch_chk(32'h0);

    // N = 0: a fresh start also clears the error
    g_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load(0, 0, -1);
    fetch_chk(32'h0);
    fetch_chk(32'h4);

    // N = 1 with 3-cycle gaps
    g_bytes.delete();
    push_word(32'd1);
    push_word($urandom);
    run_load(3, 3, -1);
    fetch_chk(32'h0);
    fetch_chk(32'h4);

    // Reset after 6 of 8 data bytes: word 0 is written, word 1 keeps its old value
    g_bytes.delete();
    push_word(32'd2);
    push_word($urandom);
    push_word($urandom);
    run_load(0, 1, 10);
    fetch_chk(32'h0);
    fetch_chk(32'h4);
    check_eq("abort_w1_old", ref_mem[1], 32'h0020_0593);

    // Largest accepted count
    rand_load(DEPTH, 0);
    fetch_chk(32'h0);
    fetch_chk(32'(4 * (DEPTH - 1)));
    fetch_chk(32'(4 * DEPTH));

    // Randomized loads and fetches
    for (int t = 0; t < 10; t++) begin
      rand_load(int'($urandom_range(6, 1)), 2);
      for (int f = 0; f < 6; f++) begin
        a = $urandom;
        if ($urandom_range(3, 0) != 0) a = a % 32'(4 * DEPTH);
        fetch_chk(a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
